// File: rtl/pwm_nch_axi_if.sv
// rtl/pwm_nch_axi_if.sv - AXI4-Lite register bus bundle for the PWM core
interface pwm_nch_axi_if #(
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/pwm_nch_axi.sv
// rtl/pwm_nch_axi.sv - N-channel PWM core with shadowed period/duty registers behind AXI4-Lite
module pwm_nch_axi #(
  parameter int NUM_CH             = 4,
  parameter int CNT_W              = 16,
  parameter int C_S_AXI_ADDR_WIDTH = 6
) (
  input  logic              ACLK,
  input  logic              ARESET,
  pwm_nch_axi_if.slave      s_axi,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_irq
);
  localparam int WA = C_S_AXI_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {W_IDLE, W_ACC, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_ACC, R_DATA} rd_state_t;

  logic [1:0]                   rst_sync;
  logic                         rst;
  wr_state_t                    wr_state, wr_next;
  rd_state_t                    rd_state, rd_next;
  logic                         wr_fire, rd_fire, upd_req;
  logic [WA-1:0]                wr_word, rd_word;
  logic [31:0]                  rd_val, rdata_q, cnt_ext;
  logic                         ctrl_en, ctrl_mode, mode_act, upd_pending;
  logic                         dir_down, center_top, boundary, load;
  logic [CNT_W-1:0]             period_sh, period_act, cnt;
  logic [NUM_CH-1:0][CNT_W-1:0] duty_sh, duty_act;
  logic                         unused_bits;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++)
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  // Reset asserts immediately, releases only after two clean edges
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) rst_sync <= 2'b11;
    else        rst_sync <= {rst_sync[0], 1'b0};
  end
  assign rst = rst_sync[1];

  always_ff @(posedge ACLK or posedge rst) begin
    if (rst) begin
      wr_state <= W_IDLE;
      rd_state <= R_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (s_axi.awvalid && s_axi.wvalid) wr_next = W_ACC;
      W_ACC:   wr_next = (s_axi.awvalid && s_axi.wvalid) ? W_RESP : W_IDLE;
      W_RESP:  if (s_axi.bready) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (s_axi.arvalid) rd_next = R_ACC;
      R_ACC:   rd_next = s_axi.arvalid ? R_DATA : R_IDLE;
      R_DATA:  if (s_axi.rready) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  assign s_axi.awready = (wr_state == W_ACC);
  assign s_axi.wready  = (wr_state == W_ACC);
  assign s_axi.bvalid  = (wr_state == W_RESP);
  assign s_axi.bresp   = 2'b00;
  assign s_axi.arready = (rd_state == R_ACC);
  assign s_axi.rvalid  = (rd_state == R_DATA);
  assign s_axi.rresp   = 2'b00;
  assign s_axi.rdata   = rdata_q;

  assign wr_fire = (wr_state == W_ACC) && s_axi.awvalid && s_axi.wvalid;
  assign rd_fire = (rd_state == R_ACC) && s_axi.arvalid;
  assign wr_word = s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign rd_word = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];
  assign upd_req = wr_fire && (wr_word == WA'(0)) && s_axi.wstrb[0] && s_axi.wdata[2];
  assign cnt_ext = 32'(cnt);

  always_comb begin
    rd_val = '0;
    if (rd_word == WA'(0)) rd_val = {30'b0, ctrl_mode, ctrl_en};
    if (rd_word == WA'(1)) rd_val = 32'(period_sh);
    if (rd_word == WA'(2)) rd_val = {cnt_ext[15:0], 15'b0, upd_pending};
    for (int i = 0; i < NUM_CH; i++)
      if (rd_word == WA'(4 + i)) rd_val = 32'(duty_sh[i]);
  end

  always_ff @(posedge ACLK or posedge rst) begin
    if (rst) rdata_q <= '0;
    else if (rd_fire) rdata_q <= rd_val;
  end

  always_ff @(posedge ACLK or posedge rst) begin
    if (rst) begin
      ctrl_en   <= 1'b0;
      ctrl_mode <= 1'b0;
      period_sh <= '0;
      duty_sh   <= '0;
    end else if (wr_fire) begin
      if (wr_word == WA'(0) && s_axi.wstrb[0]) begin
        ctrl_en   <= s_axi.wdata[0];
        ctrl_mode <= s_axi.wdata[1];
      end
      if (wr_word == WA'(1))
        period_sh <= CNT_W'(merge_bytes(32'(period_sh), s_axi.wdata, s_axi.wstrb));
      for (int i = 0; i < NUM_CH; i++)
        if (wr_word == WA'(4 + i))
          duty_sh[i] <= CNT_W'(merge_bytes(32'(duty_sh[i]), s_axi.wdata, s_axi.wstrb));
    end
  end

  // Center mode wraps on the last down step, or at the peak when the period is 1
  assign center_top = !dir_down && (cnt >= period_act);
  assign boundary = ctrl_en && (mode_act ?
                    ((period_act == '0) || (dir_down && cnt <= CNT_W'(1)) ||
                     (center_top && period_act == CNT_W'(1))) :
                    (cnt >= period_act));
  assign load = upd_pending && (boundary || !ctrl_en);

  always_ff @(posedge ACLK or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      dir_down    <= 1'b0;
      mode_act    <= 1'b0;
      period_act  <= '0;
      duty_act    <= '0;
      upd_pending <= 1'b0;
      pwm_out     <= '0;
      period_irq  <= 1'b0;
    end else begin
      if (upd_req)   upd_pending <= 1'b1;
      else if (load) upd_pending <= 1'b0;
      if (load) begin
        period_act <= period_sh;
        duty_act   <= duty_sh;
      end
      if (boundary || !ctrl_en) mode_act <= ctrl_mode;

      if (!ctrl_en || boundary) begin
        cnt      <= '0;
        dir_down <= 1'b0;
      end else if (!mode_act || (!dir_down && !center_top)) begin
        cnt <= cnt + CNT_W'(1);
      end else if (center_top) begin
        cnt      <= period_act - CNT_W'(1);
        dir_down <= 1'b1;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end

      period_irq <= boundary;
      for (int i = 0; i < NUM_CH; i++)
        pwm_out[i] <= ctrl_en && (cnt < duty_act[i]);
    end
  end

  assign unused_bits = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0],
                         s_axi.araddr[1:0], cnt_ext[31:16]};
endmodule
